// File: rtl/l2_bank_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_bank_rr_arbiter_if
// Bundles the requester-side TCDM signals and the SRAM-bank signals of the
// L2 bank round-robin arbiter. Signal names keep the legacy port names so the
// arbiter body and any existing wrappers map one-to-one.
//   slave  : arbiter view (takes m_* requests and mem_rdata_i, drives grants,
//            responses and the SRAM request bus)
//   master : environment view (requesters plus bank macro)
// Signals:
//   m_req_i/m_wen_i/m_add_i/m_wdata_i/m_be_i  per-master request bus
//   m_gnt_o/m_r_valid_o/m_r_rdata_o/m_r_opc_o grant and response
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o/mem_rdata_i  bank side
//   init_done_o                                bank available to masters
// ---------------------------------------------------------------------------
interface l2_bank_rr_arbiter_if #(
  parameter int unsigned NB_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [NB_MASTERS-1:0]                 m_req_i;
  logic [NB_MASTERS-1:0]                 m_wen_i;
  logic [NB_MASTERS-1:0][31:0]           m_add_i;
  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i;
  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i;
  logic [NB_MASTERS-1:0]                 m_gnt_o;
  logic [NB_MASTERS-1:0]                 m_r_valid_o;
  logic [DATA_WIDTH-1:0]                 m_r_rdata_o;
  logic                                  m_r_opc_o;

  logic                                  mem_req_o;
  logic                                  mem_we_o;
  logic [ADDR_WIDTH-1:0]                 mem_addr_o;
  logic [DATA_WIDTH-1:0]                 mem_wdata_o;
  logic [BE_WIDTH-1:0]                   mem_be_o;
  logic [DATA_WIDTH-1:0]                 mem_rdata_i;

  logic                                  init_done_o;

  modport slave (
    input  m_req_i, m_wen_i, m_add_i, m_wdata_i, m_be_i, mem_rdata_i,
    output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output init_done_o
  );

  modport master (
    output m_req_i, m_wen_i, m_add_i, m_wdata_i, m_be_i, mem_rdata_i,
    input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  init_done_o
  );
endinterface

// File: rtl/l2_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// l2_bank_rr_arbiter
// Shares one single-ported L2 SRAM bank (1-cycle read latency) between
// NB_MASTERS TCDM requesters with fair round-robin arbitration. The grant is
// combinational; the response valid is the grant delayed by one cycle and the
// read data is passed straight through from the bank.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous reset, active-low
//   bus     l2_bank_rr_arbiter_if.slave (requester bus, bank bus, init_done_o)
//
// Configuration:
//   L2_ARB_MEM_INIT_EN  when defined, the bank is zero-filled after reset
//                       (2**ADDR_WIDTH cycles) before any master is granted.
//                       When undefined the arbiter runs from reset.
// ---------------------------------------------------------------------------
module l2_bank_rr_arbiter #(
  parameter int unsigned NB_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  l2_bank_rr_arbiter_if.slave   bus
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int unsigned CW       = IDX_W + 1;

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [NB_MASTERS-1:0] r_valid_q, r_valid_d;

  logic                  run;
  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [CW-1:0]         cand_sum;
  logic [NB_MASTERS-1:0] gnt;
  logic [31:0]           addr_off;
  logic                  unused_addr_bits;

`ifdef L2_ARB_MEM_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // One zero-write per cycle; leave INIT after the last address is written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run = (state_q == ST_RUN);
`else
  assign run = 1'b1;
`endif

  // Round-robin pick: first requester at or after ptr_q, wrapping modulo
  // NB_MASTERS. The sum is one bit wider so non-power-of-two counts wrap too.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_sum = '0;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      cand_sum = {1'b0, ptr_q} + CW'(i);
      if (cand_sum >= CW'(NB_MASTERS)) cand_sum = cand_sum - CW'(NB_MASTERS);
      if (!found && bus.m_req_i[cand_sum[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (run && found) gnt[winner] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (run && found) begin
      ptr_d = (winner == IDX_W'(NB_MASTERS - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign r_valid_d = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      r_valid_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      r_valid_q <= r_valid_d;
    end
  end

  // Bank-relative word address; bits above the bank size are dropped.
  assign addr_off         = bus.m_add_i[winner] - BASE_ADDR;
  assign unused_addr_bits = ^{addr_off[31:ADDR_WIDTH+2], addr_off[1:0]};

  always_comb begin
    bus.mem_req_o   = |bus.m_req_i;
    bus.mem_we_o    = ~bus.m_wen_i[winner];
    bus.mem_addr_o  = addr_off[ADDR_WIDTH+1:2];
    bus.mem_wdata_o = bus.m_wdata_i[winner];
    bus.mem_be_o    = bus.m_be_i[winner];
`ifdef L2_ARB_MEM_INIT_EN
    if (!run) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = 1'b1;
      bus.mem_addr_o  = cnt_q;
      bus.mem_wdata_o = '0;
      bus.mem_be_o    = {BE_WIDTH{1'b1}};
    end
`endif
  end

  assign bus.m_gnt_o     = gnt;
  assign bus.m_r_valid_o = r_valid_q;
  assign bus.m_r_rdata_o = bus.mem_rdata_i;
  assign bus.m_r_opc_o   = 1'b0;
  assign bus.init_done_o = run;

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_bank_rr_arbiter
// Self-checking bench for l2_bank_rr_arbiter (4 masters, 16-word bank).
// A behavioural SRAM answers the bank port; a reference round-robin model and
// reference memory predict grants, bank addresses and responses. Expected
// responses are queued when a cycle is driven and popped when r_valid is due.
// Works with and without L2_ARB_MEM_INIT_EN.
// ---------------------------------------------------------------------------
module tb_l2_bank_rr_arbiter;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  l2_bank_rr_arbiter_if #(.NB_MASTERS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  l2_bank_rr_arbiter #(
    .NB_MASTERS(NB),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  // Behavioural bank: 1-cycle read latency, byte-enabled writes.
  logic [DW-1:0] sram [2**AW];
  logic [DW-1:0] sram_rdata_q;
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**AW; i++) sram[i] <= '0;
    end else if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < DW/8; b++)
          if (bus.mem_be_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_q <= sram[bus.mem_addr_o];
      end
    end
  end
  assign bus.mem_rdata_i = sram_rdata_q;

  typedef struct {
    logic [NB-1:0] vld;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [$];
  int unsigned   mptr;
  logic [DW-1:0] ref_mem [2**AW];
  int            n_vec  = 0;
  int            n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_m(input int k, input logic req, input logic wen,
                       input logic [31:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    bus.m_req_i[k]   = req;
    bus.m_wen_i[k]   = wen;
    bus.m_add_i[k]   = a;
    bus.m_wdata_i[k] = d;
    bus.m_be_i[k]    = be;
  endtask

  task automatic clr_all();
    for (int k = 0; k < NB; k++) set_m(k, 1'b0, 1'b1, BASE, '0, 4'h0);
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    mptr = 0;
  endtask

  // Called just after a negedge with inputs already driven; returns at the
  // next negedge with the response for this cycle checked.
  task automatic step();
    exp_t          e;
    int            w;
    logic [31:0]   off;
    logic [AW-1:0] word;
    logic          exp_we;
    #2;
    w = -1;
    for (int i = 0; i < NB; i++) begin
      int c;
      c = (int'(mptr) + i) % NB;
      if (w < 0 && bus.m_req_i[c]) w = c;
    end
    e.vld = '0; e.rd = 1'b0; e.data = '0;
    if (w >= 0) begin
      e.vld[w] = 1'b1;
      off    = bus.m_add_i[w] - BASE;
      word   = off[AW+1:2];
      exp_we = ~bus.m_wen_i[w];
      chk("mem_addr", bus.mem_addr_o, word);
      chk("mem_we", bus.mem_we_o, exp_we);
      if (bus.m_wen_i[w]) begin
        e.rd   = 1'b1;
        e.data = ref_mem[word];
      end else begin
        for (int b = 0; b < DW/8; b++)
          if (bus.m_be_i[w][b]) ref_mem[word][8*b +: 8] = bus.m_wdata_i[w][8*b +: 8];
      end
      mptr = (w + 1) % NB;
    end
    chk("gnt", bus.m_gnt_o, e.vld);
    chk("mem_req", bus.mem_req_o, |bus.m_req_i);
    sb.push_back(e);
    @(posedge clk_i); #1;
    e = sb.pop_front();
    chk("r_valid", bus.m_r_valid_o, e.vld);
    if (e.rd) chk("r_rdata", bus.m_r_rdata_o, e.data);
    @(negedge clk_i);
  endtask

  // Waits (bounded) for the bank to become available after reset release.
  task automatic wait_init();
`ifdef L2_ARB_MEM_INIT_EN
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      #2;
      if (bus.init_done_o) break;
      chk("init_gnt", bus.m_gnt_o, '0);
      chk("init_addr", bus.mem_addr_o, i[AW-1:0]);
      chk("init_rvalid", bus.m_r_valid_o, '0);
      @(negedge clk_i);
      n++;
    end
    chk("init_len", n, 2**AW);
    @(negedge clk_i);
`else
    chk("init_done", bus.init_done_o, 1'b1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_all();
    ref_clear();
    rst_ni = 1'b0;
    #3;
    chk("rst_rvalid", bus.m_r_valid_o, '0);
    chk("rst_gnt", bus.m_gnt_o, '0);
    chk("rst_opc", bus.m_r_opc_o, 1'b0);
`ifdef L2_ARB_MEM_INIT_EN
    chk("rst_memreq", bus.mem_req_o, 1'b1);
    chk("rst_memaddr", bus.mem_addr_o, '0);
    chk("rst_initdone", bus.init_done_o, 1'b0);
`else
    chk("rst_initdone", bus.init_done_o, 1'b1);
`endif
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

`ifdef L2_ARB_MEM_INIT_EN
    // Requests during INIT are ignored; a reset pulse mid-INIT restarts at 0.
    set_m(0, 1'b1, 1'b1, BASE, '0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("init_gnt", bus.m_gnt_o, '0);
      chk("init_addr", bus.mem_addr_o, i[AW-1:0]);
      @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    chk("init_rst_addr", bus.mem_addr_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
`endif
    wait_init();
    clr_all();

    // Idle cycle
    step();

    // Write then read word 4 from master 0
    set_m(0, 1'b1, 1'b0, BASE + 32'h10, 32'h1234_5678, 4'hF);
    step();
    set_m(0, 1'b1, 1'b1, BASE + 32'h10, '0, 4'hF);
    step();
    clr_all();

    // Master 3 alone, then 0 and 3 together: pointer wrapped to 0
    set_m(3, 1'b1, 1'b1, BASE + 32'h20, '0, 4'hF);
    step();
    set_m(0, 1'b1, 1'b1, BASE + 32'h10, '0, 4'hF);
    step();
    step();
    clr_all();

    // All masters request for 8 cycles, distinct words
    for (int k = 0; k < NB; k++) set_m(k, 1'b1, 1'b1, BASE + 32'(4*k), '0, 4'hF);
    repeat (8) step();
    clr_all();

    // Partial-BE write from master 2 to word 7, read back by master 1
    set_m(2, 1'b1, 1'b0, BASE + 32'h1C, 32'hDEAD_BEEF, 4'b0011);
    step();
    clr_all();
    set_m(1, 1'b1, 1'b1, BASE + 32'h1C, '0, 4'hF);
    step();
    // Single master back-to-back; high address bits alias onto word 1
    set_m(1, 1'b1, 1'b1, BASE + 32'h0000_0444, '0, 4'hF);
    repeat (3) step();
    clr_all();

    // Mixed traffic: masters 1 and 2 write, 0 and 3 read
    set_m(0, 1'b1, 1'b1, BASE + 32'h1C, '0, 4'hF);
    set_m(1, 1'b1, 1'b0, BASE + 32'h24, 32'hA5A5_0F0F, 4'b1100);
    set_m(2, 1'b1, 1'b0, BASE + 32'h28, 32'h0BAD_F00D, 4'hF);
    set_m(3, 1'b1, 1'b1, BASE + 32'h24, '0, 4'hF);
    repeat (6) step();
    clr_all();

    // Reset with a response pending drops it and resets the pointer
    set_m(2, 1'b1, 1'b1, BASE + 32'h0C, '0, 4'hF);
    #2;
    chk("mid_gnt", bus.m_gnt_o, 4'b0100);
    @(posedge clk_i); #1;
    chk("mid_rvalid", bus.m_r_valid_o, 4'b0100);
    clr_all();
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.m_r_valid_o, '0);
    ref_clear();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_init();
    for (int k = 0; k < NB; k++) set_m(k, 1'b1, 1'b1, BASE + 32'(4*k), '0, 4'hF);
    repeat (2) step();
    clr_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
